div_unit: RTL and testbench

Iterative radix-2 restoring integer divider in the EXU, alongside the multiply-accumulate unit. It executes DIV, DIVU, REM and REMU on XLEN-bit operands and produces one quotient bit per cycle. It writes back through the same out/rd/tag/instr port set as the other EXU units. Issue stalls on div_busy; the block is not pipelined and holds one operation at a time.

---
 rtl/div_unit_if.sv | 26 ++
 rtl/div_unit.sv | 190 +++++++++++++++++++
 tb/tb_div_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - issue and write-back signal bundle for the iterative divider.
interface div_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic [1:0]      in_op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] instr_tag;
  logic [31:0]     instr;
  logic [XLEN-1:0] out;
  logic [4:0]      out_rd_addr;
  logic            out_rd_wr_en;
  logic [XLEN-1:0] instr_tag_out;
  logic [31:0]     instr_out;
  logic            div_busy;

  modport master (
    output in_valid, in_op, rs1_data, rs2_data, rd_addr, instr_tag, instr,
    input  out, out_rd_addr, out_rd_wr_en, instr_tag_out, instr_out, div_busy
  );

  modport slave (
    input  in_valid, in_op, rs1_data, rs2_data, rd_addr, instr_tag, instr,
    output out, out_rd_addr, out_rd_wr_en, instr_tag_out, instr_out, div_busy
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     freeze,
  div_unit_if.slave io
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic [XLEN-1:0] out_tag_q, out_tag_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic            wr_q, wr_d;

  logic            is_signed;
  logic            finish;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  // quo_q holds the dividend until ITER shifts quotient bits in from the right.
  assign is_signed = ~op_q[0];
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign trial     = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    rd_d        = rd_q;
    tag_d       = tag_q;
    instr_d     = instr_q;
    res_d       = res_q;
    out_rd_d    = out_rd_q;
    out_tag_d   = out_tag_q;
    out_instr_d = out_instr_q;
    wr_d        = 1'b0;
    finish      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          op_d    = io.in_op;
          quo_d   = io.rs1_data;
          dvs_d   = io.rs2_data;
          rd_d    = io.rd_addr;
          tag_d   = io.instr_tag;
          instr_d = io.instr;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        if (dvs_q == '0) begin
          res_d  = op_q[1] ? quo_q : '1;
          finish = 1'b1;
        end else if (is_signed && quo_q == MIN_VAL && dvs_q == '1) begin
          res_d  = op_q[1] ? '0 : quo_q;
          finish = 1'b1;
        end else begin
          // The most negative dividend negates to itself, read as unsigned 2^(XLEN-1).
          quo_d   = (is_signed && quo_q[XLEN-1]) ? negate(quo_q) : quo_q;
          dvs_d   = (is_signed && dvs_q[XLEN-1]) ? negate(dvs_q) : dvs_q;
          qneg_d  = is_signed & (quo_q[XLEN-1] ^ dvs_q[XLEN-1]);
          rneg_d  = is_signed & quo_q[XLEN-1];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (op_q[1]) begin
          res_d = rneg_q ? negate(rem_q) : rem_q;
        end else begin
          res_d = qneg_q ? negate(quo_q) : quo_q;
        end
        finish = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish) begin
      state_d     = S_DONE;
      wr_d        = 1'b1;
      out_rd_d    = rd_q;
      out_tag_d   = tag_q;
      out_instr_d = instr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      rd_q        <= '0;
      tag_q       <= '0;
      instr_q     <= '0;
      res_q       <= '0;
      out_rd_q    <= '0;
      out_tag_q   <= '0;
      out_instr_q <= '0;
      wr_q        <= 1'b0;
    end else if (!freeze) begin
      state_q     <= state_d;
      op_q        <= op_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      rd_q        <= rd_d;
      tag_q       <= tag_d;
      instr_q     <= instr_d;
      res_q       <= res_d;
      out_rd_q    <= out_rd_d;
      out_tag_q   <= out_tag_d;
      out_instr_q <= out_instr_d;
      wr_q        <= wr_d;
    end
  end

  assign io.out           = res_q;
  assign io.out_rd_addr   = out_rd_q;
  assign io.out_rd_wr_en  = wr_q;
  assign io.instr_tag_out = out_tag_q;
  assign io.instr_out     = out_instr_q;
  assign io.div_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - vector table, random reference-model and corner-sequence bench for div_unit.
module tb_div_unit;

  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  logic freeze;
  int   n_checks;
  int   n_errs;

  div_unit_if #(.XLEN(XLEN)) bus ();

  div_unit #(.XLEN(XLEN)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .io     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic with the two architectural special cases.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic   ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 2;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return XLEN + 3;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] tag, input logic [31:0] ins,
                       input int frz_at, input int pulse_at,
                       output logic [31:0] res, output int lat);
    int edges;
    bit done;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    bus.rd_addr   = rd;
    bus.instr_tag = tag;
    bus.instr     = ins;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.rs1_data  = $urandom;
    bus.rs2_data  = $urandom;
    bus.rd_addr   = 5'($urandom);
    bus.instr_tag = $urandom;
    bus.instr     = $urandom;
    edges = 1;
    done  = 0;
    check("busy_after_accept", 64'(bus.div_busy), 64'd1);
    while (!done && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus.out_rd_wr_en) begin
        done = 1;
      end else begin
        if (frz_at > 0 && edges == frz_at) freeze = 1'b1;
        if (frz_at > 0 && edges == frz_at + 5) freeze = 1'b0;
        if (pulse_at > 0 && edges == pulse_at) begin
          bus.in_valid = 1'b1;
          bus.in_op    = 2'($urandom);
        end
        if (pulse_at > 0 && edges == pulse_at + 1) bus.in_valid = 1'b0;
      end
    end
    freeze       = 1'b0;
    bus.in_valid = 1'b0;
    res = bus.out;
    lat = edges;
    check("rd_echo", 64'(bus.out_rd_addr), 64'(rd));
    check("tag_echo", 64'(bus.instr_tag_out), 64'(tag));
    check("instr_echo", 64'(bus.instr_out), 64'(ins));
    @(posedge clk);
    #1;
    check("strobe_one_cycle", 64'(bus.out_rd_wr_en), 64'd0);
    check("idle_after_done", 64'(bus.div_busy), 64'd0);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          extra;

    n_checks = 0;
    n_errs   = 0;
    rst_n    = 1'b0;
    freeze   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    bus.rd_addr   = '0;
    bus.instr_tag = '0;
    bus.instr     = '0;

    vecs[0]  = '{2'b00, 32'd100,        32'd7,          32'd14,         35};
    vecs[1]  = '{2'b10, 32'd100,        32'd7,          32'd2,          35};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35};
    vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  35};
    vecs[5]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          35};
    vecs[6]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  35};
    vecs[7]  = '{2'b11, 32'hFFFF_FFFF,  32'h10,         32'hF,          35};
    vecs[8]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
    vecs[9]  = '{2'b11, 32'd5,          32'd0,          32'd5,          2};
    vecs[10] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
    vecs[11] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          2};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_rd", 64'(bus.out_rd_addr), 64'd0);
    check("rst_wr_en", 64'(bus.out_rd_wr_en), 64'd0);
    check("rst_tag", 64'(bus.instr_tag_out), 64'd0);
    check("rst_instr", 64'(bus.instr_out), 64'd0);
    check("rst_busy", 64'(bus.div_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 32'hA000 + 32'(i), 32'h1234_0000 + 32'(i),
            0, 0, res, lat);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        3:       b = -($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      do_op(op, a, b, 5'($urandom), $urandom, $urandom, 0, 0, res, lat);
      check($sformatf("rand%0d_result op=%0d a=%0h b=%0h", i, op, a, b), 64'(res), 64'(ref_div(op, a, b)));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_lat(op, a, b)));
    end

    do_op(2'b00, 32'd100, 32'd7, 5'd9, 32'hF00D, 32'hCAFE_0001, 10, 0, res, lat);
    check("freeze_result", 64'(res), 64'd14);
    check("freeze_latency", 64'(lat), 64'd40);

    do_op(2'b00, 32'hFFFF_FC18, 32'd33, 5'd12, 32'hBEEF, 32'hCAFE_0002, 0, 8, res, lat);
    check("pulse_result", 64'(res), 64'(ref_div(2'b00, 32'hFFFF_FC18, 32'd33)));
    check("pulse_latency", 64'(lat), 64'd35);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_rd_wr_en) extra++;
    end
    check("pulse_no_extra_wb", 64'(extra), 64'd0);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b01;
    bus.rs1_data = 32'd1000;
    bus.rs2_data = 32'd3;
    bus.rd_addr  = 5'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out", 64'(bus.out), 64'd0);
    check("abort_rd", 64'(bus.out_rd_addr), 64'd0);
    check("abort_tag", 64'(bus.instr_tag_out), 64'd0);
    check("abort_instr", 64'(bus.instr_out), 64'd0);
    check("abort_busy", 64'(bus.div_busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_rd_wr_en) extra++;
    end
    check("abort_no_wb", 64'(extra), 64'd0);

    do_op(2'b01, 32'd9, 32'd3, 5'd3, 32'h55, 32'h66, 0, 0, res, lat);
    check("post_reset_result", 64'(res), 64'd3);
    check("post_reset_latency", 64'(lat), 64'd35);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
